// File: rtl/mic_level_meter.sv
// Windowed microphone volume meter: per-window peak above the idle midpoint is
// quantised to a 4-bit level, with peak-hold, a thermometer LED bar and a loud flag.
module mic_level_meter #(
    parameter int unsigned WINDOW       = 4000,
    parameter int unsigned OFFSET       = 2048,
    parameter int unsigned SHIFT        = 7,
    parameter int unsigned HOLD_WINDOWS = 5,
    parameter int unsigned THRESH       = 13
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        E,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic [3:0]  level,
    output logic [3:0]  hold_level,
    output logic        level_valid,
    output logic        loud,
    output logic [15:0] led
);

    localparam logic [15:0] WinLast  = 16'(WINDOW - 1);
    localparam logic [15:0] HoldLast = 16'(HOLD_WINDOWS - 1);
    localparam logic [11:0] Offset   = 12'(OFFSET);

    logic [15:0] win_cnt_q, win_cnt_d;
    logic [11:0] run_max_q, run_max_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  hold_level_q, hold_level_d;
    logic        level_valid_q, level_valid_d;
    logic        loud_q, loud_d;
    logic [15:0] led_q, led_d;

    logic        accept;
    logic        win_end;
    logic [11:0] pk;
    logic [11:0] amp;
    logic [11:0] amp_sh;
    logic [3:0]  lv;

    always_comb begin
        accept  = E && sample_valid;
        win_end = accept && (win_cnt_q == WinLast);
        pk      = (sample > run_max_q) ? sample : run_max_q;
        amp     = (pk > Offset) ? (pk - Offset) : 12'd0;
        amp_sh  = amp >> SHIFT;
        lv      = (amp_sh > 12'd15) ? 4'd15 : amp_sh[3:0];
    end

    always_comb begin
        win_cnt_d     = win_cnt_q;
        run_max_d     = run_max_q;
        hold_cnt_d    = hold_cnt_q;
        level_d       = level_q;
        hold_level_d  = hold_level_q;
        level_valid_d = 1'b0;
        loud_d        = loud_q;
        led_d         = led_q;

        if (!E) begin
            // Disabled meter behaves like a synchronous reset held every cycle.
            win_cnt_d    = '0;
            run_max_d    = '0;
            hold_cnt_d   = '0;
            level_d      = '0;
            hold_level_d = '0;
            loud_d       = 1'b0;
            led_d        = '0;
        end else if (win_end) begin
            win_cnt_d     = '0;
            run_max_d     = '0;
            level_d       = lv;
            level_valid_d = 1'b1;
            loud_d        = ({28'd0, lv} >= THRESH);
            led_d         = (16'd1 << lv) - 16'd1;
            if (lv >= hold_level_q) begin
                hold_level_d = lv;
                hold_cnt_d   = '0;
            end else if (hold_cnt_q == HoldLast) begin
                hold_level_d = hold_level_q - 4'd1;
                hold_cnt_d   = '0;
            end else begin
                hold_cnt_d = hold_cnt_q + 16'd1;
            end
        end else if (accept) begin
            win_cnt_d = win_cnt_q + 16'd1;
            run_max_d = pk;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q     <= '0;
            run_max_q     <= '0;
            hold_cnt_q    <= '0;
            level_q       <= '0;
            hold_level_q  <= '0;
            level_valid_q <= 1'b0;
            loud_q        <= 1'b0;
            led_q         <= '0;
        end else begin
            win_cnt_q     <= win_cnt_d;
            run_max_q     <= run_max_d;
            hold_cnt_q    <= hold_cnt_d;
            level_q       <= level_d;
            hold_level_q  <= hold_level_d;
            level_valid_q <= level_valid_d;
            loud_q        <= loud_d;
            led_q         <= led_d;
        end
    end

    assign level       = level_q;
    assign hold_level  = hold_level_q;
    assign level_valid = level_valid_q;
    assign loud        = loud_q;
    assign led         = led_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter: directed windows push hand-computed
// results; a negedge monitor pops and compares on every level_valid pulse.
module tb_mic_level_meter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        E = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = '0;
    logic [3:0]  level;
    logic [3:0]  hold_level;
    logic        level_valid;
    logic        loud;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;
    int win_no = 0;

    typedef struct {
        logic [3:0]  lv;
        logic [3:0]  hold;
        logic        ld;
        logic [15:0] led;
    } exp_t;

    exp_t exp_q[$];

    mic_level_meter #(
        .WINDOW(4),
        .OFFSET(2048),
        .SHIFT(7),
        .HOLD_WINDOWS(5),
        .THRESH(13)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .E(E),
        .sample_valid(sample_valid),
        .sample(sample),
        .level(level),
        .hold_level(hold_level),
        .level_valid(level_valid),
        .loud(loud),
        .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " level"}, 32'(level), 32'd0);
        chk({tag, " hold_level"}, 32'(hold_level), 32'd0);
        chk({tag, " level_valid"}, 32'(level_valid), 32'd0);
        chk({tag, " loud"}, 32'(loud), 32'd0);
        chk({tag, " led"}, 32'(led), 32'd0);
    endtask

    // Monitor: every level_valid pulse must match the oldest expected window.
    always @(negedge clk) begin
        if (level_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: level=%0d with no window expected at %0t",
                         level, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                win_no++;
                chk($sformatf("win%0d level", win_no), 32'(level), 32'(e.lv));
                chk($sformatf("win%0d hold_level", win_no), 32'(hold_level), 32'(e.hold));
                chk($sformatf("win%0d loud", win_no), 32'(loud), 32'(e.ld));
                chk($sformatf("win%0d led", win_no), 32'(led), 32'(e.led));
            end
        end
    end

    // Called at a negedge; holds sample_valid across exactly one posedge.
    task automatic put(input logic [11:0] s);
        sample       = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic window(input logic [11:0] s0, input logic [11:0] s1,
                          input logic [11:0] s2, input logic [11:0] s3,
                          input logic [3:0] lv, input logic [3:0] hold,
                          input logic ld, input logic [15:0] led_e);
        exp_t e;
        put(s0);
        put(s1);
        put(s2);
        e.lv   = lv;
        e.hold = hold;
        e.ld   = ld;
        e.led  = led_e;
        exp_q.push_back(e);
        put(s3);
    endtask

    task automatic clear_meter();
        E = 1'b0;
        @(negedge clk);
        @(negedge clk);
        E = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and long idle enable
        #3;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        E       = 1'b1;
        repeat (10000) @(negedge clk);
        chk_zero("idle");

        // Full-scale window
        window(12'd2048, 12'd2048, 12'd4095, 12'd2048, 4'd15, 4'd15, 1'b1, 16'h7FFF);
        @(negedge clk);
        chk("full_scale pulse_width", 32'(level_valid), 32'd0);

        // Quantisation boundaries
        clear_meter();
        window(12'd100, 12'd2048, 12'd50, 12'd0, 4'd0, 4'd0, 1'b0, 16'h0000);
        window(12'd100, 12'd2175, 12'd50, 12'd0, 4'd0, 4'd0, 1'b0, 16'h0000);
        window(12'd100, 12'd2176, 12'd50, 12'd0, 4'd1, 4'd1, 1'b0, 16'h0001);
        window(12'd100, 12'd2944, 12'd50, 12'd0, 4'd7, 4'd7, 1'b0, 16'h007F);
        window(12'd1000, 12'd0, 12'd500, 12'd999, 4'd0, 4'd7, 1'b0, 16'h0000);

        // Hold decay: peak 10, then ten silent windows
        clear_meter();
        window(12'd0, 12'd3400, 12'd0, 12'd0, 4'd10, 4'd10, 1'b0, 16'h03FF);
        for (int w = 1; w <= 10; w++) begin
            logic [3:0] h;
            h = (w < 5) ? 4'd10 : (w < 10) ? 4'd9 : 4'd8;
            window(12'd2000, 12'd2000, 12'd2000, 12'd2000, 4'd0, h, 1'b0, 16'h0000);
        end

        // Enable drop on the window-ending sample
        clear_meter();
        put(12'd2048);
        put(12'd2048);
        put(12'd2048);
        sample       = 12'd4095;
        sample_valid = 1'b1;
        E            = 1'b0;
        @(negedge clk);
        sample_valid = 1'b0;
        chk_zero("e_drop");
        E = 1'b1;
        @(negedge clk);
        window(12'd0, 12'd0, 12'd0, 12'd2300, 4'd1, 4'd1, 1'b0, 16'h0001);

        // Mid-window asynchronous reset
        put(12'd4095);
        put(12'd4095);
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        window(12'd0, 12'd0, 12'd0, 12'd2176, 4'd1, 4'd1, 1'b0, 16'h0001);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("windows_seen", 32'(win_no), 32'd19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_level_meter.md
# mic_level_meter

Converts the raw 12-bit microphone sample stream into a windowed 4-bit volume level, a peak-hold level, a 16-LED bar and a loud-sound flag. It sits directly downstream of the audio capture stage. It runs on the 100 MHz system clock and accepts one sample per `sample_valid` strobe (20 kHz sample rate). Its `level` output is the volume number consumed by the volume display, pong, tetris, passcode and state-change logic.

## Interface
- `WINDOW`, 4000: samples per measurement window (200 ms at 20 kHz); legal range 2..65535.
- `OFFSET`, 2048: mic idle midpoint; sample values at or below it count as silence.
- `SHIFT`, 7: right-shift applied to the above-offset amplitude.
- `HOLD_WINDOWS`, 5: number of consecutive lower windows before `hold_level` decays by 1.
- `THRESH`, 13: `loud` asserts when `level >= THRESH`.
- `clk`  in  1: 100 MHz system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `E`  in  1: enable; low freezes and clears the meter.
- `sample_valid`  in  1: one-`clk` strobe marking a new sample.
- `sample`  in  12: unsigned mic sample.
- `level`  out  4: volume of the last completed window, 0..15.
- `hold_level`  out  4: peak-hold volume.
- `level_valid`  out  1: one-cycle pulse when `level` updates.
- `loud`  out  1: registered `level >= THRESH`.
- `led`  out  16: thermometer bar of `level`.

## Operation
- **Reset (`reset_n` low, asynchronous):** all of the following clear to 0: `level`, `hold_level`, `level_valid`, `loud`, `led`, the sample counter `win_cnt`, the running max `run_max` and the hold counter `hold_cnt`.
- **`E` low:** same clear as reset, applied synchronously every cycle. `sample_valid` is ignored. When `E` rises, a fresh window starts at `win_cnt = 0`.
- **Accepted sample** (`E` and `sample_valid` both high):
  - `run_max` takes `max(run_max, sample)`.
  - `win_cnt` increments.
- **Window end** (accepted sample while `win_cnt == WINDOW-1`):
  - `pk = max(run_max, sample)`.
  - `amp = (pk > OFFSET) ? pk - OFFSET : 0`, computed 12 bits wide.
  - `lv = min(15, amp >> SHIFT)`.
  - `level` takes `lv`.
  - `level_valid` pulses high.
  - `loud` takes `lv >= THRESH`.
  - `led[i] = (i < lv)` for i = 0..15. `led[15]` is therefore always 0.
  - `run_max` clears to 0 and `win_cnt` clears to 0.
- **Peak hold** (evaluated only at window end, using the new `lv`):
  - If `lv >= hold_level`: `hold_level` takes `lv` and `hold_cnt` takes 0.
  - Else if `hold_cnt == HOLD_WINDOWS-1`: `hold_level` decrements by 1 and `hold_cnt` takes 0.
  - Else `hold_cnt` increments.
- **Between window ends:** `level`, `hold_level`, `loud` and `led` hold their values. `level_valid` is 0.
- **Out-of-range samples:** no saturation is needed on input; all 4096 values are legal. `pk = 4095` gives `amp = 2047` and `lv = 15`.

## Timing
- A sample is accepted on the rising edge where `sample_valid` is high. At most one sample is accepted per cycle.
- `level`, `hold_level`, `loud`, `led` and `level_valid` all update on the same edge that accepts the final sample of a window. There is no additional pipeline latency.
- `level_valid` is high for exactly one `clk` cycle per window.
- `sample_valid` held high for several cycles counts one sample per cycle. No edge detection is done in this block.
- If `E` falls in the same cycle as a window-ending sample, `E` wins: outputs clear and no `level_valid` pulse is issued.
- Reset asserted mid-window discards the partial window. After reset releases, the next window needs a full `WINDOW` samples.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset and enable:** reset, then `E=1` with no `sample_valid` for 10000 cycles -> all outputs 0 and no `level_valid` pulse.
- **Full-scale window:** `WINDOW=4`, samples 2048, 2048, 4095, 2048 -> on the 4th accepted sample `level=15`, `loud=1`, `led=16'h7FFF`, `hold_level=15`, and `level_valid` pulses once.
- **Quantization boundaries:** `WINDOW=4`, with peaks of 2048, 2175, 2176, 2944 and 1000 in successive windows -> `level` = 0, 0, 1, 7, 0 respectively; `led` = 16'h0000, 16'h0000, 16'h0001, 16'h007F, 16'h0000.
- **Hold decay:** `HOLD_WINDOWS=5`, one window at `level=10`, then ten windows at `level=0` -> `hold_level` reads 10 for windows 1-4 after the peak, 9 at window 5, and 8 at window 10.
- **Enable drop:** drop `E` on the exact cycle of a window-ending sample (peak 4095), then raise it again -> no `level_valid` pulse, outputs 0, and the next pulse comes after another full `WINDOW` samples.
- **Mid-window reset:** assert `reset_n=0` after 2 of 4 samples (with `WINDOW=4`) -> all outputs 0 asynchronously; after release the next window needs 4 new samples, and the earlier peak does not affect `level`.
